// File: rtl/index_mask_decoder_if.sv
// Bitmap-in / index-out stream bundle for index_mask_decoder.
// The slave modport is the decoder's view; the master modport drives bitmaps and consumes beats.
interface index_mask_decoder_if #(
    parameter int MASK_W = 64,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [MASK_W-1:0] in_mask;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_first;
    logic              out_eom;
    logic              out_last;
    logic              out_empty;
    logic [CNT_W-1:0]  out_nz_cnt;

    modport slave (
        input  in_valid, in_mask, in_last, out_ready,
        output in_ready, out_valid, out_idx, out_first, out_eom, out_last, out_empty, out_nz_cnt
    );

    modport master (
        output in_valid, in_mask, in_last, out_ready,
        input  in_ready, out_valid, out_idx, out_first, out_eom, out_last, out_empty, out_nz_cnt
    );
endinterface

// File: rtl/index_mask_decoder.sv
// Serialises a nonzero-position bitmap into one weight index per cycle, lowest bit first.
// Define INDEX_DEC_STATS_EN to add saturating mask/index/stall counters.
module index_mask_decoder #(
    parameter int MASK_W = 64,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    index_mask_decoder_if.slave  s_bus
`ifdef INDEX_DEC_STATS_EN
    ,
    output logic [31:0]          o_stat_masks,
    output logic [31:0]          o_stat_idx,
    output logic [31:0]          o_stat_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [MASK_W-1:0]  r_rem, w_rem_next;
    logic               r_rem_last, w_rem_last_next;
    logic               r_first, w_first_next;
    logic [CNT_W-1:0]   r_nz_cnt, w_nz_cnt_next;

    logic               w_busy;
    logic               w_empty;
    logic [MASK_W-1:0]  w_rem_clr;
    logic [MASK_W-1:0]  w_lowest;
    logic [IDX_W-1:0]   w_idx;
    logic [CNT_W-1:0]   w_in_pop;
    logic               w_eom;
    logic               w_out_hs;
    logic               w_in_ready;
    logic               w_in_acc;
    logic [MASK_W-1:0]  w_sel [IDX_W];

    assign w_busy    = (r_state != ST_IDLE);
    assign w_empty   = (r_state == ST_FLUSH);
    assign w_rem_clr = r_rem & (r_rem - 1'b1);
    assign w_lowest  = r_rem & (~r_rem + 1'b1);

    // One-hot lowest bit -> binary: index bit gi is set when the hot position has bit gi set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_enc
            for (gj = 0; gj < MASK_W; gj++) begin : g_sel
                assign w_sel[gi][gj] = ((gj >> gi) % 2) == 1;
            end
            assign w_idx[gi] = |(w_lowest & w_sel[gi]);
        end
    endgenerate

    always_comb begin
        w_in_pop = '0;
        for (int i = 0; i < MASK_W; i++) begin
            w_in_pop = w_in_pop + CNT_W'(s_bus.in_mask[i]);
        end
    end

    assign w_eom      = w_busy & (w_empty | (w_rem_clr == '0));
    assign w_out_hs   = w_busy & s_bus.out_ready;
    assign w_in_ready = !w_busy | (w_out_hs & w_eom);
    assign w_in_acc   = s_bus.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_rem_last <= 1'b0;
            r_first    <= 1'b0;
            r_nz_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rem      <= w_rem_next;
            r_rem_last <= w_rem_last_next;
            r_first    <= w_first_next;
            r_nz_cnt   <= w_nz_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rem_next      = r_rem;
        w_rem_last_next = r_rem_last;
        w_first_next    = r_first;
        w_nz_cnt_next   = r_nz_cnt;
        if (w_out_hs && !w_eom) begin
            w_rem_next   = w_rem_clr;
            w_first_next = 1'b0;
        end else if (w_in_acc) begin
            // Load covers both the idle case and the no-bubble overlap with a final beat.
            if (s_bus.in_mask != '0) begin
                w_state_next    = ST_SCAN;
                w_rem_next      = s_bus.in_mask;
                w_rem_last_next = s_bus.in_last;
                w_first_next    = 1'b1;
                w_nz_cnt_next   = w_in_pop;
            end else if (s_bus.in_last) begin
                w_state_next    = ST_FLUSH;
                w_rem_next      = '0;
                w_rem_last_next = 1'b1;
                w_first_next    = 1'b1;
                w_nz_cnt_next   = '0;
            end else begin
                w_state_next    = ST_IDLE;
                w_rem_next      = '0;
                w_rem_last_next = 1'b0;
                w_first_next    = 1'b0;
                w_nz_cnt_next   = '0;
            end
        end else if (w_out_hs) begin
            w_state_next    = ST_IDLE;
            w_rem_next      = '0;
            w_rem_last_next = 1'b0;
            w_first_next    = 1'b0;
            w_nz_cnt_next   = '0;
        end
    end

    assign s_bus.in_ready   = w_in_ready;
    assign s_bus.out_valid  = w_busy;
    assign s_bus.out_idx    = w_idx;
    assign s_bus.out_first  = r_first;
    assign s_bus.out_eom    = w_eom;
    assign s_bus.out_last   = w_eom & r_rem_last;
    assign s_bus.out_empty  = w_empty;
    assign s_bus.out_nz_cnt = r_nz_cnt;

`ifdef INDEX_DEC_STATS_EN
    logic [31:0] r_stat_masks, r_stat_idx, r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_masks <= '0;
            r_stat_idx   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_in_acc && r_stat_masks != '1)
                r_stat_masks <= r_stat_masks + 1'b1;
            if (w_out_hs && !w_empty && r_stat_idx != '1)
                r_stat_idx <= r_stat_idx + 1'b1;
            if (w_busy && !s_bus.out_ready && r_stat_stall != '1)
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign o_stat_masks = r_stat_masks;
    assign o_stat_idx   = r_stat_idx;
    assign o_stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_index_mask_decoder.sv
// Bench for index_mask_decoder: per-bitmap expected beat queue plus directed literal checks.
module tb_index_mask_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    index_mask_decoder_if #(.MASK_W(64), .IDX_W(6), .CNT_W(7)) bus ();

`ifdef INDEX_DEC_STATS_EN
    logic [31:0] stat_masks, stat_idx, stat_stall;
    index_mask_decoder dut (.clk(clk), .rst(rst), .s_bus(bus),
                            .o_stat_masks(stat_masks), .o_stat_idx(stat_idx), .o_stat_stall(stat_stall));
`else
    index_mask_decoder dut (.clk(clk), .rst(rst), .s_bus(bus));
`endif

    typedef struct {
        int   idx;
        logic first;
        logic eom;
        logic last;
        logic empty;
        int   nz;
    } beat_t;

    beat_t q[$];
    int total = 0;
    int bad   = 0;

    logic       obs_valid, obs_ready, obs_first, obs_eom, obs_last, obs_empty;
    int         obs_idx, obs_nz;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats for one accepted bitmap, straight from the set-bit list.
    function automatic void push_mask(input logic [63:0] m, input logic l);
        int n = 0;
        int j = 0;
        beat_t b;
        for (int i = 0; i < 64; i++) if (m[i]) n++;
        if (n == 0) begin
            if (l) begin
                b = '{idx: 0, first: 1'b1, eom: 1'b1, last: 1'b1, empty: 1'b1, nz: 0};
                q.push_back(b);
            end
            return;
        end
        for (int i = 0; i < 64; i++) begin
            if (m[i]) begin
                b.idx = i; b.first = (j == 0); b.eom = (j == n - 1);
                b.last = l && (j == n - 1); b.empty = 1'b0; b.nz = n;
                q.push_back(b);
                j++;
            end
        end
    endfunction

    // One cycle: drive inputs after negedge, check outputs, advance the model at posedge.
    task automatic step(input logic v, input logic [63:0] m, input logic l, input logic rdy, input logic r);
        logic exp_valid, exp_ready;
        bus.in_valid = v; bus.in_mask = m; bus.in_last = l; bus.out_ready = rdy; rst = r;
        #1;
        obs_valid = bus.out_valid; obs_ready = bus.in_ready; obs_idx = int'(bus.out_idx);
        obs_first = bus.out_first; obs_eom = bus.out_eom; obs_last = bus.out_last;
        obs_empty = bus.out_empty; obs_nz = int'(bus.out_nz_cnt);
        exp_valid = (q.size() != 0);
        exp_ready = !exp_valid || (rdy && q[0].eom);
        if (!r) begin
            chk("out_valid", obs_valid, exp_valid);
            chk("in_ready", obs_ready, exp_ready);
            if (exp_valid) begin
                chk("out_empty", obs_empty, q[0].empty);
                chk("out_eom", obs_eom, q[0].eom);
                chk("out_last", obs_last, q[0].last);
                chk("out_nz_cnt", obs_nz, q[0].nz);
                if (!q[0].empty) begin
                    chk("out_idx", obs_idx, q[0].idx);
                    chk("out_first", obs_first, q[0].first);
                end
            end
        end
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (exp_valid && rdy) void'(q.pop_front());
            if (v && exp_ready) push_mask(m, l);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] m;
        int cnt_v, last_idx, last_cnt;
        bus.in_valid = 0; bus.in_mask = '0; bus.in_last = 0; bus.out_ready = 0;
        @(negedge clk);
        repeat (3) step(0, '0, 0, 0, 1);

        // Reset state
        step(0, '0, 0, 1, 0);
        chk("rst out_valid", obs_valid, 0); chk("rst in_ready", obs_ready, 1);
        chk("rst out_idx", obs_idx, 0); chk("rst out_last", obs_last, 0);
        chk("rst out_eom", obs_eom, 0); chk("rst out_nz_cnt", obs_nz, 0);
        chk("rst out_first", obs_first, 0); chk("rst out_empty", obs_empty, 0);

        // Stall on 0xF0
        step(1, 64'hF0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, '0, 0, 0, 0);
            chk("stall idx", obs_idx, 4); chk("stall in_ready", obs_ready, 0);
        end
        for (int k = 4; k < 8; k++) begin
            step(0, '0, 0, 1, 0);
            chk("release idx", obs_idx, k);
        end
`ifdef INDEX_DEC_STATS_EN
        chk("stat_stall", stat_stall, 5);
        chk("stat_idx", stat_idx, 4);
        chk("stat_masks", stat_masks, 1);
`endif

        // 0x8001
        step(1, 64'h8001, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        chk("8001 idx0", obs_idx, 0); chk("8001 first", obs_first, 1); chk("8001 nz", obs_nz, 2);
        step(0, '0, 0, 1, 0);
        chk("8001 idx15", obs_idx, 15); chk("8001 eom", obs_eom, 1); chk("8001 last", obs_last, 0);

        // Zero bitmaps
        step(1, '0, 1, 1, 0);
        step(0, '0, 0, 1, 0);
        chk("zl valid", obs_valid, 1); chk("zl empty", obs_empty, 1); chk("zl last", obs_last, 1);
        chk("zl eom", obs_eom, 1); chk("zl nz", obs_nz, 0);
        step(1, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        chk("z valid", obs_valid, 0); chk("z in_ready", obs_ready, 1);

        // Back-to-back 0x3 then 0x100
        step(1, 64'h3, 0, 1, 0);
        step(1, 64'h100, 1, 1, 0);
        chk("b2b idx0", obs_idx, 0); chk("b2b last0", obs_last, 0);
        step(1, 64'h100, 1, 1, 0);
        chk("b2b idx1", obs_idx, 1); chk("b2b last1", obs_last, 0);
        step(0, '0, 0, 1, 0);
        chk("b2b idx8", obs_idx, 8); chk("b2b last8", obs_last, 1); chk("b2b valid8", obs_valid, 1);

        // All ones
        step(1, '1, 1, 1, 0);
        cnt_v = 0; last_idx = -1; last_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            step(0, '0, 0, 1, 0);
            if (obs_valid) cnt_v++;
            if (obs_last) begin last_cnt++; last_idx = obs_idx; end
        end
        chk("ones beats", cnt_v, 64); chk("ones last cnt", last_cnt, 1); chk("ones last idx", last_idx, 63);
        step(0, '0, 0, 1, 0);
        chk("ones done", obs_valid, 0);

        // Reset on the third beat of 0xFF
        step(1, 64'hFF, 1, 1, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 1);
        chk("mid-rst third idx", obs_idx, 2);
        step(0, '0, 0, 1, 0);
        chk("mid-rst valid", obs_valid, 0); chk("mid-rst in_ready", obs_ready, 1);
        chk("mid-rst last", obs_last, 0);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 9))
                0:       m = '0;
                1:       m = 64'd1 << $urandom_range(0, 63);
                2:       m = '1;
                3:       m = {$urandom, $urandom};
                default: m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            endcase
            step(($urandom_range(0, 2) != 0), m, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/index_mask_decoder.md
# index_mask_decoder

Downstream consumer of the index/sign buffer read path. It accepts one 64-bit nonzero-position bitmap per handshake and serialises it into a stream of 6-bit weight indices for the sparse 4-bit MAC address generator, one index per cycle, lowest bit first. Zero bitmaps are skipped. The end-of-kernel-group marker is preserved, so the MAC side sees exactly one `out_last` per group.

## Interface
- `MASK_W`, 64, bitmap width (power of two).
- `IDX_W`, 6, index width; must equal log2(`MASK_W`).
- `CNT_W`, 7, popcount width; must equal `IDX_W`+1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  bitmap valid.
- `in_ready`  out  1  bitmap accepted when `in_valid & in_ready`.
- `in_mask`  in  `MASK_W`  bitmap; bit i set means weight i is nonzero.
- `in_last`  in  1  bitmap is the final one of the kernel group.
- `out_valid`  out  1  index beat valid.
- `out_ready`  in  1  beat consumed when `out_valid & out_ready`.
- `out_idx`  out  `IDX_W`  position of the current lowest set bit.
- `out_first`  out  1  first beat of the current bitmap.
- `out_eom`  out  1  last beat of the current bitmap.
- `out_last`  out  1  `out_eom` of a bitmap accepted with `in_last`.
- `out_empty`  out  1  group-end beat from a zero bitmap; `out_idx` is don't-care on this beat.
- `out_nz_cnt`  out  `CNT_W`  popcount of the current bitmap, held for all of its beats.

## Operation
- State is held in the registers `busy`, `rem` (`MASK_W`), `rem_last`, `first`, `empty`, and `nz_cnt`.
- States:
  - IDLE: `busy`=0.
  - SCAN: `busy`=1, `rem`≠0.
  - FLUSH: `busy`=1, `empty`=1.
- `out_valid` = `busy`.
- `out_idx` = priority encode of the lowest set bit of `rem`, computed combinationally from registers.
- `out_eom` = `busy` & (`empty` | (`rem & (rem-1)`)==0).
- `out_last` = `out_eom` & `rem_last`.
- `out_first` = `first`.
- `in_ready` = !`busy` | (`out_valid & out_ready & out_eom`). The final beat and a new bitmap overlap with no bubble.
- On accept of a nonzero bitmap: go to SCAN with `rem`=`in_mask`, `rem_last`=`in_last`, `first`=1, `empty`=0, `nz_cnt`=popcount(`in_mask`).
- On accept of a zero bitmap with `in_last`=1: go to FLUSH, `rem_last`=1, `nz_cnt`=0.
- On accept of a zero bitmap with `in_last`=0: the bitmap is consumed with no beat and the block stays or returns to IDLE.
- On an output handshake that is not `out_eom`: clear the lowest set bit of `rem` and set `first`=0.
- On an output handshake with `out_eom`:
  - With a simultaneous accept, load the new bitmap per the rules above.
  - Without one, go to IDLE.
- When `busy`=0, `rem`, `rem_last`, `first` and `empty` are 0.
- `out_valid` never drops without a handshake. Outputs stay stable while `out_valid & !out_ready`.
- `in_mask` is sampled only on accept. Bits outside `MASK_W` do not exist.

## Timing
- Reset values: `busy`=0, `rem`=0, `out_valid`=0, `out_idx`=0, `out_first`=0, `out_eom`=0, `out_last`=0, `out_empty`=0, `out_nz_cnt`=0. `in_ready`=1 in the first cycle after reset.
- Latency: a bitmap accepted at edge N gives its first beat valid in cycle N+1.
- Throughput:
  - One index per cycle.
  - A bitmap with k set bits occupies exactly k cycles under continuous `out_ready`.
  - A zero group-end bitmap occupies 1 cycle; other zero bitmaps occupy 0 output cycles.
- Reset mid-operation: `rst` overrides every handshake in the same cycle. The remaining bits are discarded and no partial `out_last` is produced.
- An all-ones bitmap yields 64 beats with indices 0..63. `nz_cnt`=64 needs all 7 bits.

## Configuration
- `INDEX_DEC_STATS_EN`: when defined, adds the following outputs, cleared by `rst` and saturating at all-ones:
  - `stat_masks` (32): accepted bitmaps.
  - `stat_idx` (32): non-empty index beats handshaken.
  - `stat_stall` (32): cycles with `out_valid & !out_ready`.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Send `in_mask`=0x0000_0000_0000_8001, `in_last`=0, with `out_ready`=1 → beats idx 0 (`first`=1, `nz_cnt`=2), then idx 15 (`eom`=1, `last`=0) in consecutive cycles starting one cycle after accept.
- Send a zero bitmap with `in_last`=1 → exactly one beat with `out_empty`=1, `out_last`=1, `out_eom`=1, `nz_cnt`=0. The same bitmap with `in_last`=0 produces no beat and `in_ready` stays 1.
- Hold `out_ready` low for 5 cycles mid-bitmap 0xF0 → idx 4 held stable with `in_ready`=0; after release, idx 4,5,6,7 follow. With stats enabled, `stat_stall`=5.
- Send back-to-back bitmaps 0x3 (`last`=0) then 0x100 (`last`=1) → beats 0, 1, 8 in 3 consecutive cycles with no bubble; `out_last` asserted only on idx 8.
- Send all-ones with `in_last`=1 → 64 beats with indices 0..63, `nz_cnt`=64, and `out_last` only on idx 63.
- Assert `rst` on the third beat of 0xFF → next cycle `out_valid`=0 and `in_ready`=1; no `out_last` is ever emitted for that bitmap.
